// File: rtl/lcd_window_fill_ctrl.sv
// Fills a rectangular window on an SPI LCD: emits CASET/RASET/RAMWR command and
// data bytes, then streams one RGB565 colour for every pixel in the window.
module lcd_window_fill_ctrl #(
  parameter int X_OFFSET = 40,
  parameter int Y_OFFSET = 53,
  parameter int WIDTH    = 240,
  parameter int HEIGHT   = 135
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [8:0]  req_x0,
  input  logic [8:0]  req_x1,
  input  logic [8:0]  req_y0,
  input  logic [8:0]  req_y1,
  input  logic [15:0] req_color,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_dc,
  output logic        tx_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET_CMD,
    S_CASET_DATA,
    S_RASET_CMD,
    S_RASET_DATA,
    S_RAMWR_CMD,
    S_PIX_HI,
    S_PIX_LO
  } state_t;

  localparam logic [7:0]  CMD_CASET = 8'h2A;
  localparam logic [7:0]  CMD_RASET = 8'h2B;
  localparam logic [7:0]  CMD_RAMWR = 8'h2C;
  localparam logic [15:0] X_OFF16   = 16'(X_OFFSET);
  localparam logic [15:0] Y_OFF16   = 16'(Y_OFFSET);
  localparam logic [9:0]  WIDTH10   = 10'(WIDTH);
  localparam logic [9:0]  HEIGHT10  = 10'(HEIGHT);

  state_t      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [19:0] pix_rem_q, pix_rem_d;
  logic [15:0] xs_q, xs_d;
  logic [15:0] xe_q, xe_d;
  logic [15:0] ys_q, ys_d;
  logic [15:0] ye_q, ye_d;
  logic [15:0] color_q, color_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic        req_bad;
  logic        hs;
  logic [9:0]  win_w;
  logic [9:0]  win_h;
  logic [19:0] win_pixels;

  // Start/end word pair for the 4-byte CASET/RASET payload, MSB first.
  function automatic logic [7:0] window_byte(input logic [15:0] start_w,
                                             input logic [15:0] end_w,
                                             input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = start_w[15:8];
      2'd1:    b = start_w[7:0];
      2'd2:    b = end_w[15:8];
      default: b = end_w[7:0];
    endcase
    return b;
  endfunction

  assign req_bad = (req_x0 > req_x1) || (req_y0 > req_y1) ||
                   ({1'b0, req_x1} >= WIDTH10) || ({1'b0, req_y1} >= HEIGHT10);
  assign win_w      = {1'b0, req_x1} - {1'b0, req_x0} + 10'd1;
  assign win_h      = {1'b0, req_y1} - {1'b0, req_y0} + 10'd1;
  assign win_pixels = 20'(win_w) * 20'(win_h);

  // Holding off acceptance while err is high keeps err pulses from merging.
  assign req_ready = (state_q == S_IDLE) && !err_q;
  assign accept    = req_valid && req_ready;
  assign tx_valid  = (state_q != S_IDLE);
  assign hs        = tx_valid && tx_ready;
  assign busy      = tx_valid;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    pix_rem_d  = pix_rem_q;
    xs_d       = xs_q;
    xe_d       = xe_q;
    ys_d       = ys_q;
    ye_d       = ye_q;
    color_d    = color_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tx_data    = 8'h00;
    tx_dc      = 1'b0;
    tx_last    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            xs_d       = 16'({7'd0, req_x0}) + X_OFF16;
            xe_d       = 16'({7'd0, req_x1}) + X_OFF16;
            ys_d       = 16'({7'd0, req_y0}) + Y_OFF16;
            ye_d       = 16'({7'd0, req_y1}) + Y_OFF16;
            color_d    = req_color;
            pix_rem_d  = win_pixels;
            byte_idx_d = 2'd0;
            state_d    = S_CASET_CMD;
          end
        end
      end
      S_CASET_CMD: begin
        tx_data = CMD_CASET;
        if (hs) state_d = S_CASET_DATA;
      end
      S_CASET_DATA: begin
        tx_dc   = 1'b1;
        tx_data = window_byte(xs_q, xe_q, byte_idx_q);
        if (hs) begin
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = S_RASET_CMD;
        end
      end
      S_RASET_CMD: begin
        tx_data = CMD_RASET;
        if (hs) state_d = S_RASET_DATA;
      end
      S_RASET_DATA: begin
        tx_dc   = 1'b1;
        tx_data = window_byte(ys_q, ye_q, byte_idx_q);
        if (hs) begin
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = S_RAMWR_CMD;
        end
      end
      S_RAMWR_CMD: begin
        tx_data = CMD_RAMWR;
        if (hs) state_d = S_PIX_HI;
      end
      S_PIX_HI: begin
        tx_dc   = 1'b1;
        tx_data = color_q[15:8];
        if (hs) state_d = S_PIX_LO;
      end
      S_PIX_LO: begin
        tx_dc   = 1'b1;
        tx_data = color_q[7:0];
        tx_last = (pix_rem_q == 20'd1);
        if (hs) begin
          if (pix_rem_q == 20'd1) begin
            pix_rem_d = 20'd0;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end else begin
            pix_rem_d = pix_rem_q - 20'd1;
            state_d   = S_PIX_HI;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      pix_rem_q  <= 20'd0;
      xs_q       <= 16'd0;
      xe_q       <= 16'd0;
      ys_q       <= 16'd0;
      ye_q       <= 16'd0;
      color_q    <= 16'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      pix_rem_q  <= pix_rem_d;
      xs_q       <= xs_d;
      xe_q       <= xe_d;
      ys_q       <= ys_d;
      ye_q       <= ye_d;
      color_q    <= color_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule
